pipe_hazard_ctrl: RTL

Pipeline controller for the five-stage core: detects ID-stage data hazards, sequences branch flushes, and runs the multi-cycle SRAM access handshake for the MEM stage. It drives the freeze/flush controls of the PC, IF/ID and ID/EX stage registers, and the global freeze of the downstream registers. It also keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_sram_access_fsm.sv | 84 ++++++++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl_pkg                                                        |
// | Shared types and constants for the pipeline hazard / SRAM access control.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int DEF_REG_W = 5;
  localparam logic [DEF_REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } sram_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sram_access_fsm.sv
// +----------------------------------------------------------------------------+
// | sram_access_fsm                                                             |
// | MEM-stage SRAM handshake: launch pulse, bounded wait, sticky timeout flag. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sram_access_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int SRAM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic sram_ready,
  output logic sram_start,
  output logic freeze_pipe,
  output logic sram_timeout_err
);

  localparam int TMO_W = $clog2(SRAM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SRAM_TIMEOUT - 1);

  sram_state_e      r_state;
  sram_state_e      w_state_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             r_err;
  logic             w_err_set;
  logic             w_start;
  logic             w_freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Ready takes precedence over the timeout in the final wait cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    w_err_set   = 1'b0;
    w_start     = 1'b0;
    w_freeze    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req) begin
          w_start     = 1'b1;
          w_freeze    = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_freeze = 1'b1;
        if (sram_ready) begin
          w_state_nxt = ST_DONE;
        end else if (r_tmo == TMO_LAST) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign sram_start       = w_start & ~rst;
  assign freeze_pipe      = w_freeze & ~rst;
  assign sram_timeout_err = r_err;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                            |
// | ID hazard detect, branch flush, SRAM freeze priority and event counters.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = DEF_REG_W,
  parameter int SRAM_TIMEOUT = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_vld,
  input  logic             id_src2_vld,
  input  logic [REG_W-1:0] ex_dst,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             ex_wb_en,
  input  logic             mem_wb_en,
  input  logic             ex_mem_read,
  input  logic             fwd_en,
  input  logic             ex_branch_taken,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             sram_ready,
  output logic             sram_start,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_pipe,
  output logic             sram_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REG_W-1:0] C_ZERO    = REG_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic             w_freeze_pipe;
  logic             w_src1_live;
  logic             w_src2_live;
  logic             w_match_ex;
  logic             w_match_mem;
  logic             w_hazard;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  sram_access_fsm #(
    .SRAM_TIMEOUT (SRAM_TIMEOUT)
  ) u_sram_fsm (
    .clk              (clk),
    .rst              (rst),
    .mem_req          (mem_rd | mem_wr),
    .sram_ready       (sram_ready),
    .sram_start       (sram_start),
    .freeze_pipe      (w_freeze_pipe),
    .sram_timeout_err (sram_timeout_err)
  );

  assign freeze_pipe = w_freeze_pipe;

  // r0 is hardwired zero, so a read of it can never depend on an older write.
  assign w_src1_live = id_src1_vld && (id_src1 != C_ZERO);
  assign w_src2_live = id_src2_vld && (id_src2 != C_ZERO);
  assign w_match_ex  = (w_src1_live && (id_src1 == ex_dst))
                     || (w_src2_live && (id_src2 == ex_dst));
  assign w_match_mem = (w_src1_live && (id_src1 == mem_dst))
                     || (w_src2_live && (id_src2 == mem_dst));

  // With forwarding, only a load in EX still leaves a one-cycle gap.
  assign w_hazard = fwd_en ? (w_match_ex && ex_wb_en && ex_mem_read)
                           : ((w_match_ex && ex_wb_en) || (w_match_mem && mem_wb_en));

  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (rst) begin
      freeze_pc = 1'b0;
    end else if (w_freeze_pipe) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
    end else if (ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (w_hazard) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      flush_id_ex  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (freeze_pc && (r_stall_cnt != C_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_if_id && (r_flush_cnt != C_CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire
